// File: rtl/uart_tx_stream.sv
// uart_tx_stream
// Byte-stream UART transmitter (8N1) with a small transmit FIFO.
// Bytes offered on in_data/in_valid are buffered and sent LSB first. The
// frame is one start bit (0), eight data bits and one stop bit (1). When the
// FIFO still holds data at the end of a stop bit, the next frame follows
// with no idle gap.
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both high. in_ready depends only on registered state and never on
// in_valid. in_data is ignored on any edge without a transfer.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_data    : byte from the producer
//   in_valid   : in_data is valid this cycle
//   in_ready   : a byte can be accepted this cycle
//   uart_tx    : serial line, idle high, driven from a flop
//   busy       : a frame is being shifted out (FSM not in IDLE)
//   fifo_count : number of bytes buffered
//   dbg_state  : current TX FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
module uart_tx_stream #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            uart_tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [1:0]                      dbg_state
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam int BAUD_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_stream: CLK_FREQ/BAUD must be at least 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_stream: FIFO_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             out_of_reset;
    logic             push;
    logic             pop;

    // out_of_reset keeps in_ready low while reset is held and raises it on
    // the first edge after release, with no dependence on in_valid.
    assign in_ready   = out_of_reset && (count < CNT_FULL);
    assign push       = in_valid && in_ready;
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_e         state, state_next;
    logic [BAUD_W-1:0] baud_cnt, baud_next;
    logic [2:0]        bit_idx, bit_next;
    logic [7:0]        data_reg, data_next;
    logic              tx_reg, tx_next;
    logic              bit_end;
    logic              have_data;
    logic [2:0]        bit_idx_inc;

    assign bit_end     = (baud_cnt == BAUD_LAST);
    assign have_data   = (count != '0);
    assign bit_idx_inc = bit_idx + 3'd1;

    assign uart_tx   = tx_reg;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            data_reg <= '0;
            tx_reg   <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            data_reg <= data_next;
            tx_reg   <= tx_next;
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        data_next  = data_reg;
        tx_next    = tx_reg;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                baud_next = '0;
                tx_next   = 1'b1;
                if (have_data) begin
                    pop        = 1'b1;
                    data_next  = mem[rd_ptr];
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end

            START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    tx_next    = data_reg[0];
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx_inc;
                        tx_next  = data_reg[bit_idx_inc];
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    baud_next = '0;
                    // Chain straight into the next start bit when data waits.
                    if (have_data) begin
                        pop        = 1'b1;
                        data_next  = mem[rd_ptr];
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                baud_next  = '0;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Testbench for uart_tx_stream with CLK_FREQ=1000, BAUD=100 (10 clocks per
// bit) and FIFO_DEPTH=4. Inputs change and outputs are sampled 1 time unit
// after each rising edge.
module tb_uart_tx_stream;

    localparam int CPB   = 10;
    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic [1:0] dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_stream #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] stim[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Line level at bit slot k of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers stim[0..n-1] back to back starting from an idle, empty block.
    // Edge c=0 carries the first push; frames are expected to start at
    // edges 1, 101, 201, ... with no gap between them.
    task automatic run_stream(input int n, input string name);
        int         idx       = 0;
        int         mdl_cnt   = 0;
        int         started   = 0;
        logic [7:0] cur_byte  = 8'h00;
        logic       push_m;
        logic       pop_m;
        logic       exp_tx;
        int         fr;
        for (int c = 0; c < 100 * n + 20; c++) begin
            in_valid = (idx < n);
            in_data  = (idx < n) ? stim[idx] : 8'hxx;
            push_m   = in_valid && (mdl_cnt < DEPTH);
            pop_m    = (c >= 1) && ((c - 1) % 100 == 0) && (started < n);
            tick();
            if (push_m) begin
                exp_q.push_back(stim[idx]);
                idx++;
            end
            if (pop_m) begin
                cur_byte = exp_q.pop_front();
                started++;
            end
            mdl_cnt = mdl_cnt + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
            fr = (c - 1) / 100;
            if (c >= 1 && fr < n) begin
                exp_tx = frame_bit(cur_byte, ((c - 1) % 100) / CPB);
            end else begin
                exp_tx = 1'b1;
            end
            check({name, "_tx"}, uart_tx, exp_tx);
            check({name, "_busy"}, busy, (c >= 1 && fr < n));
            check({name, "_count"}, fifo_count, mdl_cnt);
            check({name, "_ready"}, in_ready, (mdl_cnt < DEPTH));
        end
        in_valid = 1'b0;
        check({name, "_all_sent"}, started, n);
        check({name, "_q_empty"}, exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset state while held
        repeat (3) tick();
        check("rst_tx", uart_tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        check("rst_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        check("rst_ready_before_edge", in_ready, 1'b0);
        tick();
        check("rst_ready_after_edge", in_ready, 1'b1);
        check("rst_state", dbg_state, 2'd0);
        repeat (3) tick();

        // Single byte 0x55
        stim[0] = 8'h55;
        run_stream(1, "single");

        // Burst 0x00..0x05: fills the FIFO, exercises full-with-pop
        for (int i = 0; i < 6; i++) stim[i] = 8'(i);
        run_stream(6, "burst");

        // Two more patterns with mixed bits
        stim[0] = 8'hA3;
        stim[1] = 8'h81;
        run_stream(2, "pair");

        // Reset mid-frame: three pushes, frame starts at edge 1, two queued
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h00;
            tick();
        end
        in_valid = 1'b0;
        check("mid_count", fifo_count, 3'd2);
        repeat (33) tick();
        check("mid_busy", busy, 1'b1);
        check("mid_tx_low", uart_tx, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", uart_tx, 1'b1);
        check("mid_rst_count", fifo_count, 3'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", in_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            tick();
            check("post_rst_tx", uart_tx, 1'b1);
            check("post_rst_busy", busy, 1'b0);
            check("post_rst_count", fifo_count, 3'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_stream.md
UART_TX_STREAM -- requirements
Module: uart_tx_stream

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, line bit rate in bit/s.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, transmit buffer depth in bytes; power of two, at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_data, input, 8 bits: byte offered by the upstream producer.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-009 The block SHALL have port uart_tx, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: a frame is being shifted out.
REQ-011 The block SHALL have port fifo_count, output, log2(FIFO_DEPTH)+1 bits: number of bytes buffered.

Function
REQ-012 CLKS_PER_BIT SHALL be CLK_FREQ/BAUD (integer division, truncated); it SHALL be at least 2, checked at elaboration.
REQ-013 in_ready SHALL be high exactly when fifo_count < FIFO_DEPTH; it is derived from registered state only, with no combinational path from in_valid.
REQ-014 A byte SHALL be accepted on a rising edge where in_valid and in_ready are both high; it is written to the FIFO tail. in_data is ignored when no byte is accepted.
REQ-015 The FIFO SHALL be first-in-first-out; read and write pointers wrap modulo FIFO_DEPTH.
REQ-016 When a push and a pop occur on the same edge, both SHALL take effect and fifo_count SHALL stay unchanged.
REQ-017 When full, no push SHALL occur (in_ready is 0), including on an edge where a pop frees a slot; the push is accepted one cycle later.
REQ-018 The TX FSM SHALL have four states: IDLE, START, DATA, STOP. busy SHALL be 1 in every state except IDLE.
REQ-019 IDLE: on an edge where fifo_count > 0, the FSM SHALL pop the head byte into the shift register, drive uart_tx to 0 and move to START.
REQ-020 Latency: a byte accepted into an empty FIFO while in IDLE at edge N SHALL drive uart_tx low at edge N+1.
REQ-021 START SHALL last exactly CLKS_PER_BIT cycles, after which the FSM enters DATA.
REQ-022 DATA SHALL send 8 bits LSB first, each lasting exactly CLKS_PER_BIT cycles, tracked by a 3-bit bit index; after bit 7 the FSM enters STOP with uart_tx = 1.
REQ-023 STOP SHALL last exactly CLKS_PER_BIT cycles.
REQ-024 At the end of STOP: if fifo_count > 0, the FSM SHALL pop the next byte and enter START on the same edge, giving back-to-back frames with no idle gap; otherwise it SHALL go to IDLE.
REQ-025 Each frame SHALL therefore last exactly 10*CLKS_PER_BIT cycles.
REQ-026 uart_tx SHALL be driven from a flop with no combinational glitches.
REQ-027 The baud counter SHALL count from 0 to CLKS_PER_BIT-1, then wrap to 0. It SHALL be held at 0 in IDLE.
REQ-028 The block SHALL not modify or drop an accepted byte, and no byte SHALL be transmitted twice.

Reset
REQ-029 While rst_n = 0, asynchronously: uart_tx = 1, busy = 0, fifo_count = 0, in_ready = 0, FSM = IDLE, and pointers, baud counter and bit index = 0.
REQ-030 On the first rising clk edge after rst_n deasserts, in_ready SHALL be 1.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately (uart_tx = 1) and discard all buffered bytes; nothing is resent after release.

Verification (CLK_FREQ=1000, BAUD=100, so CLKS_PER_BIT=10; FIFO_DEPTH=4)
REQ-032 Reset check: hold rst_n = 0 -> uart_tx=1, busy=0, fifo_count=0, in_ready=0; one edge after release -> in_ready=1.
REQ-033 Single byte: push 0x55 at edge N -> uart_tx low over edges N+1..N+10, then bits 1,0,1,0,1,0,1,0 for 10 cycles each, stop high for 10 cycles; busy falls at edge N+101 and fifo_count returns to 0.
REQ-034 Burst: hold in_valid with bytes 0x00..0x05 -> in_ready drops when fifo_count=4; all six frames leave in order, back to back, with no idle cycle between stop and start; 600 cycles in total.
REQ-035 Full with pop: fill to 4 during a frame and keep in_valid high -> on the STOP-end edge fifo_count goes 4->3 with no push; next edge push, fifo_count=4.
REQ-036 Reset mid-frame: assert rst_n 35 cycles into a frame with 2 bytes queued -> uart_tx=1 asynchronously, fifo_count=0; after release the line stays idle high indefinitely.
